// File: rtl/seq_alu_if.sv
// Operand/result bundle and start/busy/done handshake between a requester and seq_alu.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic [3:0]         op;
  logic [WIDTH-1:0]   Y;
  logic [WIDTH-1:0]   BusMuxOut;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] C;
  logic               div_by_zero;

  modport master (
    output start, op, Y, BusMuxOut,
    input  busy, done, C, div_by_zero
  );

  modport slave (
    input  start, op, Y, BusMuxOut,
    output busy, done, C, div_by_zero
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative signed shift-add MUL and
// iterative signed non-restoring DIV, with registered result and start/busy/done handshake.
module seq_alu #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SH_W  = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      clr,
  seq_alu_if.slave bus
);

  localparam logic [3:0] OpAnd  = 4'd0;
  localparam logic [3:0] OpOr   = 4'd1;
  localparam logic [3:0] OpNeg  = 4'd2;
  localparam logic [3:0] OpNot  = 4'd3;
  localparam logic [3:0] OpAdd  = 4'd4;
  localparam logic [3:0] OpSub  = 4'd5;
  localparam logic [3:0] OpMul  = 4'd6;
  localparam logic [3:0] OpDiv  = 4'd7;
  localparam logic [3:0] OpShr  = 4'd8;
  localparam logic [3:0] OpShra = 4'd9;
  localparam logic [3:0] OpShl  = 4'd10;
  localparam logic [3:0] OpRor  = 4'd11;
  localparam logic [3:0] OpRol  = 4'd12;

  localparam logic [SH_W-1:0] CntLast = SH_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMulIter, StDivIter, StDivFix} state_e;

  state_e               r_state, w_state_next;
  logic [2*WIDTH-1:0]   r_c, w_c_next;
  logic                 r_done, w_done_next;
  logic                 r_dbz, w_dbz_next;
  logic [SH_W-1:0]      r_cnt, w_cnt_next;
  logic [2*WIDTH-1:0]   r_acc, w_acc_next;
  logic [2*WIDTH-1:0]   r_mcand, w_mcand_next;
  logic [WIDTH-1:0]     r_mplier, w_mplier_next;
  logic [WIDTH+1:0]     r_rem, w_rem_next;
  logic [WIDTH-1:0]     r_quo, w_quo_next;
  logic [WIDTH-1:0]     r_dvsr, w_dvsr_next;
  logic                 r_neg_q, w_neg_q_next;
  logic                 r_neg_r, w_neg_r_next;

  logic [WIDTH-1:0]     w_a, w_b, w_abs_a, w_abs_b, w_single;
  logic [SH_W-1:0]      w_sh;
  logic [WIDTH-1:0]     w_rot_r, w_rot_l;
  logic                 w_accept;
  logic                 w_last;
  logic [2*WIDTH-1:0]   w_addend, w_acc_sum;
  logic [WIDTH+1:0]     w_dvsr_ext, w_rem_sh, w_rem_step;
  logic [WIDTH-1:0]     w_rem_mag, w_rem_out, w_quo_out;

  assign w_a      = bus.Y;
  assign w_b      = bus.BusMuxOut;
  assign w_sh     = w_b[SH_W-1:0];
  assign w_abs_a  = w_a[WIDTH-1] ? -w_a : w_a;
  assign w_abs_b  = w_b[WIDTH-1] ? -w_b : w_b;
  assign w_rot_r  = WIDTH'({w_a, w_a} >> w_sh);
  assign w_rot_l  = WIDTH'(({w_a, w_a} << w_sh) >> WIDTH);
  assign w_accept = bus.start && (r_state == StIdle);

  always_comb begin
    w_single = '0;
    case (bus.op)
      OpAnd:   w_single = w_a & w_b;
      OpOr:    w_single = w_a | w_b;
      OpNeg:   w_single = -w_b;
      OpNot:   w_single = ~w_b;
      OpAdd:   w_single = w_a + w_b;
      OpSub:   w_single = w_a - w_b;
      OpShr:   w_single = w_a >> w_sh;
      OpShra:  w_single = $signed(w_a) >>> w_sh;
      OpShl:   w_single = w_a << w_sh;
      OpRor:   w_single = w_rot_r;
      OpRol:   w_single = w_rot_l;
      default: w_single = '0;
    endcase
  end

  // Multiplier bit W-1 carries negative weight, so the final partial product is subtracted.
  assign w_last    = (r_cnt == CntLast);
  assign w_addend  = !r_mplier[0] ? '0 : (w_last ? -r_mcand : r_mcand);
  assign w_acc_sum = r_acc + w_addend;

  // Unsigned non-restoring step on magnitudes; signs are applied in StDivFix.
  assign w_dvsr_ext = {2'b00, r_dvsr};
  assign w_rem_sh   = {r_rem[WIDTH:0], r_quo[WIDTH-1]};
  assign w_rem_step = r_rem[WIDTH+1] ? w_rem_sh + w_dvsr_ext : w_rem_sh - w_dvsr_ext;
  assign w_rem_mag  = WIDTH'(r_rem[WIDTH+1] ? r_rem + w_dvsr_ext : r_rem);
  assign w_rem_out  = r_neg_r ? -w_rem_mag : w_rem_mag;
  assign w_quo_out  = r_neg_q ? -r_quo : r_quo;

  always_comb begin
    w_state_next  = r_state;
    w_c_next      = r_c;
    w_done_next   = 1'b0;
    w_dbz_next    = r_dbz;
    w_cnt_next    = r_cnt;
    w_acc_next    = r_acc;
    w_mcand_next  = r_mcand;
    w_mplier_next = r_mplier;
    w_rem_next    = r_rem;
    w_quo_next    = r_quo;
    w_dvsr_next   = r_dvsr;
    w_neg_q_next  = r_neg_q;
    w_neg_r_next  = r_neg_r;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_dbz_next = 1'b0;
          w_cnt_next = '0;
          case (bus.op)
            OpMul: begin
              w_acc_next    = '0;
              w_mcand_next  = {{WIDTH{w_a[WIDTH-1]}}, w_a};
              w_mplier_next = w_b;
              w_state_next  = StMulIter;
            end
            OpDiv: begin
              if (w_b == '0) begin
                w_c_next    = {w_a, {WIDTH{1'b1}}};
                w_dbz_next  = 1'b1;
                w_done_next = 1'b1;
              end else begin
                w_rem_next   = '0;
                w_quo_next   = w_abs_a;
                w_dvsr_next  = w_abs_b;
                w_neg_q_next = w_a[WIDTH-1] ^ w_b[WIDTH-1];
                w_neg_r_next = w_a[WIDTH-1];
                w_state_next = StDivIter;
              end
            end
            default: begin
              w_c_next    = {{WIDTH{1'b0}}, w_single};
              w_done_next = 1'b1;
            end
          endcase
        end
      end
      StMulIter: begin
        w_acc_next    = w_acc_sum;
        w_mcand_next  = r_mcand << 1;
        w_mplier_next = r_mplier >> 1;
        w_cnt_next    = r_cnt + SH_W'(1);
        if (w_last) begin
          w_c_next     = w_acc_sum;
          w_done_next  = 1'b1;
          w_state_next = StIdle;
        end
      end
      StDivIter: begin
        w_rem_next = w_rem_step;
        w_quo_next = {r_quo[WIDTH-2:0], ~w_rem_step[WIDTH+1]};
        w_cnt_next = r_cnt + SH_W'(1);
        if (w_last) begin
          w_state_next = StDivFix;
        end
      end
      StDivFix: begin
        w_c_next     = {w_rem_out, w_quo_out};
        w_done_next  = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= StIdle;
      r_c      <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_c      <= w_c_next;
      r_done   <= w_done_next;
      r_dbz    <= w_dbz_next;
      r_cnt    <= w_cnt_next;
      r_acc    <= w_acc_next;
      r_mcand  <= w_mcand_next;
      r_mplier <= w_mplier_next;
      r_rem    <= w_rem_next;
      r_quo    <= w_quo_next;
      r_dvsr   <= w_dvsr_next;
      r_neg_q  <= w_neg_q_next;
      r_neg_r  <= w_neg_r_next;
    end
  end

  assign bus.busy        = (r_state != StIdle);
  assign bus.done        = r_done;
  assign bus.C           = r_c;
  assign bus.div_by_zero = r_dbz;

endmodule
